// File: rtl/booth_seq_divider.sv
// booth_seq_divider: iterative signed divider, one restoring step per clock plus a sign-fix cycle
//   Ports: clk, rst (async active-low), start, dividend[DW], divisor[VW] in;
//          quotient[DW], remainder[VW], busy, done out; dbz, ovf out when BOOTH_DIV_FLAGS_EN is defined.
//   Quotient truncates toward zero, remainder takes the dividend's sign. Divide-by-zero skips
//   straight to the fix cycle and yields quotient -1, remainder 0.
module booth_seq_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          busy,
    output logic          done
`ifdef BOOTH_DIV_FLAGS_EN
    ,
    output logic          dbz,
    output logic          ovf
`endif
);
    localparam int CW = $clog2(DW + 1);
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [VW-1:0] rem_q, rem_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic          sd_q, sd_d, sv_q, sv_d;
    logic [DW-1:0] quotient_q, quotient_d;
    logic [VW-1:0] remainder_q, remainder_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic [VW:0]   shifted;
    logic [VW+1:0] trial;
`ifdef BOOTH_DIV_FLAGS_EN
    logic          dbz_q, dbz_d, ovf_q, ovf_d;
`endif
    // quo_q starts as |dividend| and is shifted out MSB-first while quotient bits shift in.
    // rem_q stays below |divisor| <= 2^(VW-1), so VW bits hold it; the shifted value needs VW+1.
    assign shifted = {rem_q, quo_q[DW-1]};
    assign trial   = {1'b0, shifted} - {2'b00, dvs_q};
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        sd_d        = sd_q;
        sv_d        = sv_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        busy_d      = busy_q;
        done_d      = state_q == S_FIX;
`ifdef BOOTH_DIV_FLAGS_EN
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
`endif
        if (state_q == S_IDLE && start) begin
            state_d = divisor == '0 ? S_FIX : S_RUN;
            count_d = CW'(DW);
            rem_d   = '0;
            quo_d   = dividend[DW-1] ? -dividend : dividend;
            dvs_d   = divisor[VW-1] ? -divisor : divisor;
            sd_d    = dividend[DW-1];
            sv_d    = divisor[VW-1];
            busy_d  = 1'b1;
`ifdef BOOTH_DIV_FLAGS_EN
            dbz_d   = 1'b0;
            ovf_d   = 1'b0;
`endif
        end else if (state_q == S_RUN) begin
            rem_d   = trial[VW+1] ? shifted[VW-1:0] : trial[VW-1:0];
            quo_d   = {quo_q[DW-2:0], ~trial[VW+1]};
            count_d = count_q - 1'b1;
            state_d = count_q == CW'(1) ? S_FIX : S_RUN;
        end else if (state_q == S_FIX) begin
            quotient_d  = dvs_q == '0 ? '1 : (sd_q ^ sv_q ? -quo_q : quo_q);
            remainder_d = sd_q ? -rem_q : rem_q;
            busy_d      = 1'b0;
            state_d     = S_IDLE;
`ifdef BOOTH_DIV_FLAGS_EN
            dbz_d       = dvs_q == '0;
            // A magnitude quotient of 2^(DW-1) from |divisor|=1 with both signs negative is the only wrap.
            ovf_d       = sd_q & sv_q & (dvs_q == VW'(1)) & (quo_q == {1'b1, {(DW-1){1'b0}}});
`endif
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            sd_q        <= 1'b0;
            sv_q        <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            sd_q        <= sd_d;
            sv_q        <= sv_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end
`ifdef BOOTH_DIV_FLAGS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dbz_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            dbz_q <= dbz_d;
            ovf_q <= ovf_d;
        end
    end
    assign dbz = dbz_q;
    assign ovf = ovf_q;
`endif
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule
